booth_product_accumulator: RTL and testbench

BOOTH_PRODUCT_ACCUMULATOR -- requirements
Module: booth_product_accumulator

---
 rtl/booth_product_accumulator.sv | 124 ++++++++++++
 tb/tb_booth_product_accumulator.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/booth_product_accumulator.sv
// Accumulates groups of signed Booth products with saturation, tracks per-group
// energy, and presents each group result under a valid/ready handshake.
module booth_product_accumulator #(
  parameter int ACC_W = 24,
  parameter int EN_W  = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [15:0]      product,
  input  logic             done,
  input  logic [7:0]       power_consumption,
  input  logic [3:0]       acc_len,
  input  logic             clear,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  output logic             sat,
  output logic [EN_W-1:0]  energy_total,
  output logic [7:0]       drop_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [EN_W-1:0]  energy;
  logic [4:0]       count;
  logic [4:0]       len;

  logic [ACC_W-1:0] product_ext;
  logic [ACC_W:0]   acc_sum;
  logic             acc_ovf;
  logic [ACC_W-1:0] acc_next;
  logic [EN_W:0]    power_ext;
  logic [EN_W:0]    energy_sum;
  logic [EN_W-1:0]  energy_next;
  logic [4:0]       start_len;

  // One extra guard bit on each sum exposes signed overflow and energy carry-out.
  always_comb begin
    product_ext       = {ACC_W{product[15]}};
    product_ext[15:0] = product;
    acc_sum  = {acc[ACC_W-1], acc} + {product_ext[ACC_W-1], product_ext};
    acc_ovf  = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
    acc_next = acc_sum[ACC_W-1:0];
    if (acc_ovf) begin
      acc_next = acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    power_ext       = '0;
    power_ext[7:0]  = power_consumption;
    energy_sum      = {1'b0, energy} + power_ext;
    energy_next     = energy_sum[EN_W] ? '1 : energy_sum[EN_W-1:0];
    start_len       = (acc_len == 4'd0) ? 5'd16 : {1'b0, acc_len};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      acc      <= '0;
      energy   <= '0;
      count    <= '0;
      len      <= '0;
      sat      <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      state  <= IDLE;
      acc    <= '0;
      energy <= '0;
      count  <= '0;
      sat    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (done) begin
            len    <= start_len;
            acc    <= product_ext;
            energy <= power_ext[EN_W-1:0];
            count  <= 5'd1;
            sat    <= 1'b0;
            state  <= (start_len == 5'd1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (done) begin
            acc    <= acc_next;
            sat    <= sat | acc_ovf;
            energy <= energy_next;
            count  <= count + 5'd1;
            if (count + 5'd1 == len) state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            // A product arriving with the handshake opens the next group directly.
            if (done) begin
              len    <= start_len;
              acc    <= product_ext;
              energy <= power_ext[EN_W-1:0];
              count  <= 5'd1;
              sat    <= 1'b0;
              state  <= (start_len == 5'd1) ? HOLD : ACCUM;
            end else begin
              acc    <= '0;
              energy <= '0;
              count  <= '0;
              sat    <= 1'b0;
              state  <= IDLE;
            end
          end else if (done && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign acc_out      = acc;
  assign energy_total = energy;
  assign acc_valid    = (state == HOLD);
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Scoreboard bench: stimulus pushes hand-computed group results, a monitor pops
// and compares them on every acc_valid/out_ready handshake.
module tb_booth_product_accumulator;

  localparam int ACC_W = 16;
  localparam int EN_W  = 10;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [15:0]      product;
  logic             done;
  logic [7:0]       power_consumption;
  logic [3:0]       acc_len;
  logic             clear;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             sat;
  logic [EN_W-1:0]  energy_total;
  logic [7:0]       drop_cnt;
  logic             busy;

  typedef struct packed {
    logic [15:0] acc;
    logic [9:0]  energy;
    logic        sat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  booth_product_accumulator #(.ACC_W(ACC_W), .EN_W(EN_W)) dut (
    .clk(clk), .reset_n(reset_n), .product(product), .done(done),
    .power_consumption(power_consumption), .acc_len(acc_len), .clear(clear),
    .out_ready(out_ready), .acc_out(acc_out), .acc_valid(acc_valid), .sat(sat),
    .energy_total(energy_total), .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic push_exp(input int a, input int e, input logic s);
    exp_t x;
    x.acc    = a[15:0];
    x.energy = e[9:0];
    x.sat    = s;
    sb.push_back(x);
  endtask

  task automatic apply_stimulus(input logic d, input int p, input int pw);
    done              = d;
    product           = p[15:0];
    power_consumption = pw[7:0];
    @(posedge clk);
    #1;
    done = 1'b0;
  endtask

  // Each negedge with valid and ready high precedes exactly one handshake edge.
  always @(negedge clk) begin
    if (reset_n && acc_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_result: got acc_out %0h, expected no result", acc_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_value("sb_acc_out", 32'(acc_out), 32'(e.acc));
        check_value("sb_energy", 32'(energy_total), 32'(e.energy));
        check_value("sb_sat", 32'(sat), 32'(e.sat));
      end
    end
  end

  initial begin
    reset_n = 1'b0; done = 1'b0; product = '0; power_consumption = '0;
    acc_len = '0; clear = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_acc_out", 32'(acc_out), 0);
    check_value("rst_acc_valid", 32'(acc_valid), 0);
    check_value("rst_busy", 32'(busy), 0);
    check_value("rst_drop_cnt", 32'(drop_cnt), 0);
    check_value("rst_energy", 32'(energy_total), 0);
    reset_n = 1'b1;

    // Three-product group with mixed signs
    acc_len = 4'd3; out_ready = 1'b1;
    apply_stimulus(1'b1, 15, 9);
    check_value("g3_busy", 32'(busy), 1);
    check_value("g3_valid_early", 32'(acc_valid), 0);
    apply_stimulus(1'b1, -15, 10);
    push_exp(15, 30, 1'b0);
    apply_stimulus(1'b1, 15, 11);
    check_value("g3_valid", 32'(acc_valid), 1);
    apply_stimulus(1'b0, 0, 0);
    check_value("g3_idle", 32'(busy), 0);

    // Positive and negative saturation
    acc_len = 4'd2;
    apply_stimulus(1'b1, 16384, 1);
    push_exp(32767, 2, 1'b1);
    apply_stimulus(1'b1, 16384, 1);
    apply_stimulus(1'b0, 0, 0);
    apply_stimulus(1'b1, -32768, 0);
    push_exp(-32768, 0, 1'b1);
    apply_stimulus(1'b1, -1, 0);
    apply_stimulus(1'b0, 0, 0);

    // acc_len 0 means sixteen products; energy clamps without setting sat
    acc_len = 4'd0;
    for (int i = 0; i < 15; i++) apply_stimulus(1'b1, 1, 100);
    check_value("len16_valid_early", 32'(acc_valid), 0);
    push_exp(16, 1023, 1'b0);
    apply_stimulus(1'b1, 1, 100);
    check_value("len16_valid", 32'(acc_valid), 1);
    apply_stimulus(1'b0, 0, 0);

    // Back-pressure drops, then handshake coincident with a new product
    acc_len = 4'd1; out_ready = 1'b0;
    push_exp(7, 1, 1'b0);
    apply_stimulus(1'b1, 7, 1);
    check_value("hold_valid", 32'(acc_valid), 1);
    apply_stimulus(1'b1, 8, 2);
    apply_stimulus(1'b1, 9, 3);
    check_value("drop_cnt_2", 32'(drop_cnt), 2);
    check_value("hold_stable", 32'(acc_out), 7);
    out_ready = 1'b1;
    push_exp(10, 4, 1'b0);
    apply_stimulus(1'b1, 10, 4);
    check_value("drop_after_hs", 32'(drop_cnt), 2);
    check_value("hs_new_valid", 32'(acc_valid), 1);
    apply_stimulus(1'b0, 0, 0);

    // clear coincident with done aborts the group silently
    acc_len = 4'd4;
    apply_stimulus(1'b1, 5, 1);
    apply_stimulus(1'b1, 6, 1);
    clear = 1'b1;
    apply_stimulus(1'b1, 100, 50);
    clear = 1'b0;
    check_value("clr_busy", 32'(busy), 0);
    check_value("clr_valid", 32'(acc_valid), 0);
    check_value("clr_drop", 32'(drop_cnt), 2);
    check_value("clr_acc", 32'(acc_out), 0);
    acc_len = 4'd2;
    apply_stimulus(1'b1, 3, 2);
    push_exp(7, 4, 1'b0);
    apply_stimulus(1'b1, 4, 2);
    apply_stimulus(1'b0, 0, 0);

    // Asynchronous reset mid-group
    acc_len = 4'd4;
    apply_stimulus(1'b1, 1, 5);
    apply_stimulus(1'b1, 2, 5);
    #2 reset_n = 1'b0;
    #1;
    check_value("async_acc", 32'(acc_out), 0);
    check_value("async_busy", 32'(busy), 0);
    check_value("async_energy", 32'(energy_total), 0);
    check_value("async_drop", 32'(drop_cnt), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    acc_len = 4'd1;
    push_exp(-5, 3, 1'b0);
    apply_stimulus(1'b1, -5, 3);
    check_value("post_rst_valid", 32'(acc_valid), 1);
    apply_stimulus(1'b0, 0, 0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL sb_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
